// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Handshake: dmem_req is the master's valid and dmem_ack the slave's ready. A transfer
// completes in any cycle with both high. Until then the master holds dmem_addr, dmem_we
// and dmem_wdata stable. dmem_rdata is meaningful only in the completing cycle of a read.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: branch resolution, data-memory access with wait/timeout FSM and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN blocks accesses whose address is not 8-byte aligned.
module mem_stage (
  input  logic        clk,
  input  logic        resetl,
  input  logic        mem_zero,
  input  logic        mem_branch,
  input  logic        mem_uncond_branch,
  input  logic [63:0] mem_aluout,
  input  logic [63:0] mem_nextseqpc,
  input  logic [63:0] mem_busB,
  input  logic [4:0]  mem_rd,
  input  logic        mem_mem2reg,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  mem_stage_if.master dmem,
  output logic        pcsrc,
  output logic [63:0] branch_target,
  output logic        mem_stall,
  output logic [63:0] wb_readdata,
  output logic [63:0] wb_aluout,
  output logic [4:0]  wb_rd,
  output logic        wb_mem2reg,
  output logic        wb_regwrite,
  output logic        mem_err,
  output logic        mem_misalign,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // The first request cycle plus WAIT cycles with count 0..253 give 255 stalled cycles.
  localparam logic [7:0] TIMEOUT_CNT = 8'd253;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       access;
  logic       misalign;
  logic       read_done;

  assign access = mem_memread | mem_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (mem_aluout[2:0] != 3'd0);
`else
  assign misalign = 1'b0;
`endif

  assign pcsrc         = (mem_branch & mem_zero) | mem_uncond_branch;
  assign branch_target = mem_nextseqpc;

  assign dmem.dmem_req   = resetl & access & ~mem_err & ~misalign;
  assign dmem.dmem_we    = mem_memwrite;
  assign dmem.dmem_addr  = mem_aluout;
  assign dmem.dmem_wdata = mem_busB;

  assign mem_stall = dmem.dmem_req & ~dmem.dmem_ack;
  assign read_done = dmem.dmem_req & dmem.dmem_ack & ~mem_memwrite;
  assign dbg_state = (state == WAIT);

  always_ff @(posedge clk) begin
    if (!resetl) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem.dmem_req && !dmem.dmem_ack) begin
            state    <= WAIT;
            wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack) begin
            state <= IDLE;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            // Give up: the stalled instruction then proceeds as an unserviced access.
            state   <= IDLE;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      wb_readdata <= 64'd0;
      wb_aluout   <= 64'd0;
      wb_rd       <= 5'd0;
      wb_mem2reg  <= 1'b0;
      wb_regwrite <= 1'b0;
    end else if (mem_stall) begin
      wb_mem2reg  <= 1'b0;
      wb_regwrite <= 1'b0;
    end else begin
      wb_readdata <= read_done ? dmem.dmem_rdata : 64'd0;
      wb_aluout   <= mem_aluout;
      wb_rd       <= mem_rd;
      wb_mem2reg  <= mem_mem2reg;
      wb_regwrite <= mem_regwrite & ~misalign;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!resetl) mem_misalign <= 1'b0;
    else         mem_misalign <= misalign;
  end
`else
  assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a cycle-level reference model checked every cycle,
// plus literal expectations for the branch, load, store, timeout, reset and alignment cases.
module tb_mem_stage;

  logic        clk;
  logic        resetl;
  logic        mem_zero, mem_branch, mem_uncond_branch;
  logic [63:0] mem_aluout, mem_nextseqpc, mem_busB;
  logic [4:0]  mem_rd;
  logic        mem_mem2reg, mem_regwrite, mem_memread, mem_memwrite;
  logic        pcsrc;
  logic [63:0] branch_target;
  logic        mem_stall;
  logic [63:0] wb_readdata, wb_aluout;
  logic [4:0]  wb_rd;
  logic        wb_mem2reg, wb_regwrite, mem_err, mem_misalign, dbg_state;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clk(clk), .resetl(resetl),
    .mem_zero(mem_zero), .mem_branch(mem_branch), .mem_uncond_branch(mem_uncond_branch),
    .mem_aluout(mem_aluout), .mem_nextseqpc(mem_nextseqpc), .mem_busB(mem_busB),
    .mem_rd(mem_rd), .mem_mem2reg(mem_mem2reg), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem(dmem_bus),
    .pcsrc(pcsrc), .branch_target(branch_target), .mem_stall(mem_stall),
    .wb_readdata(wb_readdata), .wb_aluout(wb_aluout), .wb_rd(wb_rd),
    .wb_mem2reg(wb_mem2reg), .wb_regwrite(wb_regwrite),
    .mem_err(mem_err), .mem_misalign(mem_misalign), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // Tracks how long the current access has been stalled; 255 stalled cycles = timeout.
  logic [63:0] m_readdata, m_aluout;
  logic [4:0]  m_rd;
  logic        m_mem2reg, m_regwrite, m_err, m_mis;
  int          m_age;
  bit          armed = 0;

  always @(negedge clk) begin
    logic acc, mis, e_req, e_stall, e_pcsrc;
    acc = mem_memread | mem_memwrite;
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc && (mem_aluout[2:0] != 3'd0);
`else
    mis = 1'b0;
`endif
    e_req   = resetl && acc && !m_err && !mis;
    e_stall = e_req && !dmem_bus.dmem_ack;
    e_pcsrc = (mem_branch && mem_zero) || mem_uncond_branch;
    if (armed) begin
      check("m_pcsrc", 64'(pcsrc), 64'(e_pcsrc));
      check("m_target", branch_target, mem_nextseqpc);
      check("m_req", 64'(dmem_bus.dmem_req), 64'(e_req));
      check("m_stall", 64'(mem_stall), 64'(e_stall));
      if (e_req) begin
        check("m_we", 64'(dmem_bus.dmem_we), 64'(mem_memwrite));
        check("m_addr", dmem_bus.dmem_addr, mem_aluout);
        check("m_wdata", dmem_bus.dmem_wdata, mem_busB);
      end
      check("m_wb_readdata", wb_readdata, m_readdata);
      check("m_wb_aluout", wb_aluout, m_aluout);
      check("m_wb_rd", 64'(wb_rd), 64'(m_rd));
      check("m_wb_mem2reg", 64'(wb_mem2reg), 64'(m_mem2reg));
      check("m_wb_regwrite", 64'(wb_regwrite), 64'(m_regwrite));
      check("m_err", 64'(mem_err), 64'(m_err));
      check("m_misalign", 64'(mem_misalign), 64'(m_mis));
      check("m_state_wait", 64'(dbg_state), 64'(m_age > 0));
    end
    if (!resetl) begin
      m_readdata = '0; m_aluout = '0; m_rd = '0;
      m_mem2reg = 0; m_regwrite = 0; m_err = 0; m_mis = 0; m_age = 0;
      armed = 1;
    end else begin
      if (e_stall) begin
        m_regwrite = 0;
        m_mem2reg  = 0;
        if (m_age + 1 == 255) begin
          m_err = 1;
          m_age = 0;
        end else begin
          m_age++;
        end
      end else begin
        m_age      = 0;
        m_readdata = (e_req && !mem_memwrite) ? dmem_bus.dmem_rdata : 64'd0;
        m_aluout   = mem_aluout;
        m_rd       = mem_rd;
        m_mem2reg  = mem_mem2reg;
        m_regwrite = mem_regwrite && !mis;
      end
      m_mis = mis;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    mem_memread = 0; mem_memwrite = 0; mem_regwrite = 0; mem_mem2reg = 0;
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = '0;
  endtask

  // Presents one access and acks it in request cycle ack_cycle (0 = never).
  // Returns after the edge at which the instruction left the stage.
  task automatic run_access(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                            input logic [63:0] rdata, input int ack_cycle, input int max_cycles,
                            output int stalls, output logic first_req, output logic first_we,
                            output logic [63:0] first_wdata);
    bit done;
    done = 0; stalls = 0;
    first_req = 0; first_we = 0; first_wdata = '0;
    mem_memread = !wr; mem_memwrite = wr; mem_aluout = addr; mem_busB = data;
    mem_regwrite = !wr; mem_mem2reg = !wr; mem_rd = 5'd9;
    for (int k = 1; k <= max_cycles && !done; k++) begin
      dmem_bus.dmem_ack   = (k == ack_cycle);
      dmem_bus.dmem_rdata = (k == ack_cycle) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      if (k == 1) begin
        first_req = dmem_bus.dmem_req; first_we = dmem_bus.dmem_we; first_wdata = dmem_bus.dmem_wdata;
      end
      if (mem_stall) stalls++;
      else done = 1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_bound stalled=%0d limit=%0d", stalls, max_cycles);
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int          st;
    logic        f_req, f_we;
    logic [63:0] f_wd;
    logic        t_wr[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] t_addr[4] = '{64'h08, 64'h10, 64'h18, 64'h20};
    logic [63:0] t_data[4] = '{64'h0, 64'hCAFE, 64'h0, 64'h1};
    logic [63:0] t_rd[4]   = '{64'h1111_2222_3333_4444, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    int          t_ack[4]  = '{1, 2, 5, 4};

    resetl = 0;
    mem_zero = 0; mem_branch = 0; mem_uncond_branch = 0;
    mem_aluout = '0; mem_nextseqpc = '0; mem_busB = '0; mem_rd = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_wb_regwrite", 64'(wb_regwrite), 64'd0);
    check("reset_wb_aluout", wb_aluout, 64'd0);
    check("reset_err", 64'(mem_err), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    resetl = 1;

    // Branch resolution
    mem_branch = 1; mem_zero = 1; mem_nextseqpc = 64'h40;
    @(negedge clk);
    check("br_taken", 64'(pcsrc), 64'd1);
    check("br_target", branch_target, 64'h40);
    @(posedge clk); #1; mem_zero = 0;
    @(negedge clk);
    check("br_not_taken", 64'(pcsrc), 64'd0);
    @(posedge clk); #1; mem_branch = 0; mem_uncond_branch = 1;
    @(negedge clk);
    check("br_uncond", 64'(pcsrc), 64'd1);
    @(posedge clk); #1; mem_uncond_branch = 0;

    // Plain ALU instruction
    mem_regwrite = 1; mem_aluout = 64'h1234; mem_rd = 5'd3;
    @(posedge clk); #1;
    check("alu_wb_aluout", wb_aluout, 64'h1234);
    check("alu_wb_rd", 64'(wb_rd), 64'd3);
    check("alu_wb_regwrite", 64'(wb_regwrite), 64'd1);
    idle_inputs();

    // Load acked in its 3rd request cycle
    run_access(0, 64'h100, 64'h0, 64'hDEAD_BEEF, 3, 10, st, f_req, f_we, f_wd);
    check("load_stall_cycles", 64'(st), 64'd2);
    check("load_readdata", wb_readdata, 64'hDEAD_BEEF);
    check("load_regwrite", 64'(wb_regwrite), 64'd1);
    check("load_rd", 64'(wb_rd), 64'd9);

    // Zero-wait store
    run_access(1, 64'h180, 64'h55, 64'h0, 1, 5, st, f_req, f_we, f_wd);
    check("store_req", 64'(f_req), 64'd1);
    check("store_we", 64'(f_we), 64'd1);
    check("store_wdata", f_wd, 64'h55);
    check("store_stall_cycles", 64'(st), 64'd0);
    @(negedge clk);
    check("store_we_drops", 64'(dmem_bus.dmem_we), 64'd0);
    @(posedge clk); #1;

    // Mixed loads/stores with varying ack latency
    for (int i = 0; i < 4; i++) begin
      run_access(t_wr[i], t_addr[i], t_data[i], t_rd[i], t_ack[i], 10, st, f_req, f_we, f_wd);
      check("tbl_stall_cycles", 64'(st), 64'(t_ack[i] - 1));
    end

    // Ack with no request outstanding is ignored
    mem_regwrite = 1; mem_aluout = 64'h77;
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 64'hBAD0_BAD0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_ack_readdata", wb_readdata, 64'd0);
    idle_inputs();

    // Alignment
`ifdef MEM_ALIGN_CHECK_EN
    run_access(0, 64'h103, 64'h0, 64'hAAAA, 1, 5, st, f_req, f_we, f_wd);
    check("mis_req", 64'(f_req), 64'd0);
    check("mis_stall_cycles", 64'(st), 64'd0);
    check("mis_pulse", 64'(mem_misalign), 64'd1);
    check("mis_regwrite", 64'(wb_regwrite), 64'd0);
    @(posedge clk); #1;
    check("mis_pulse_end", 64'(mem_misalign), 64'd0);
`else
    run_access(0, 64'h103, 64'h0, 64'hAAAA, 1, 5, st, f_req, f_we, f_wd);
    check("unaligned_req", 64'(f_req), 64'd1);
    check("unaligned_readdata", wb_readdata, 64'hAAAA);
    check("misalign_tied", 64'(mem_misalign), 64'd0);
`endif

    // Reset while waiting
    mem_memread = 1; mem_aluout = 64'h200; mem_regwrite = 1; mem_rd = 5'd4;
    repeat (4) @(posedge clk);
    #1;
    check("rst_wait_entered", 64'(dbg_state), 64'd1);
    resetl = 0;
    @(negedge clk);
    check("rst_req_forced", 64'(dmem_bus.dmem_req), 64'd0);
    @(posedge clk); #1;
    check("rst_state_idle", 64'(dbg_state), 64'd0);
    check("rst_wb_aluout", wb_aluout, 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_regwrite", 64'(wb_regwrite), 64'd0);
    idle_inputs();
    resetl = 1;
    @(posedge clk); #1;

    // Timeout: load never acked
    run_access(0, 64'h300, 64'h0, 64'h0, 0, 300, st, f_req, f_we, f_wd);
    check("to_stall_cycles", 64'(st), 64'd255);
    check("to_err", 64'(mem_err), 64'd1);
    check("to_readdata", wb_readdata, 64'd0);
    run_access(1, 64'h308, 64'h99, 64'h0, 1, 5, st, f_req, f_we, f_wd);
    check("to_store_dropped", 64'(f_req), 64'd0);
    run_access(0, 64'h310, 64'h0, 64'h1234_5678, 1, 5, st, f_req, f_we, f_wd);
    check("to_load_req", 64'(f_req), 64'd0);
    check("to_load_zero", wb_readdata, 64'd0);
    check("to_err_sticky", 64'(mem_err), 64'd1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use clock clk and reset resetl, where resetl is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 resetl  in  1  synchronous active-low reset.
REQ-004 mem_zero, mem_branch, mem_uncond_branch  in  1 each  branch controls from the EX/MEM register.
REQ-005 mem_aluout, mem_nextseqpc, mem_busB  in  64 each  address/result, branch target, store data.
REQ-006 mem_rd  in  5  destination register.
REQ-007 mem_mem2reg, mem_regwrite, mem_memread, mem_memwrite  in  1 each  controls.
REQ-008 dmem_req, dmem_we  out  1  memory request and write enable.
REQ-009 dmem_addr, dmem_wdata  out  64  memory address and write data.
REQ-010 dmem_ack  in  1  access complete.
REQ-011 dmem_rdata  in  64  read data, valid with dmem_ack.
REQ-012 pcsrc  out  1  redirect PC.
REQ-013 branch_target  out  64  redirect address.
REQ-014 mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
REQ-015 wb_readdata, wb_aluout  out  64  registered MEM/WB data.
REQ-016 wb_rd  out  5  registered destination register.
REQ-017 wb_mem2reg, wb_regwrite  out  1  registered WB controls.
REQ-018 mem_err  out  1  sticky timeout flag.
REQ-019 mem_misalign  out  1  misalignment pulse; see REQ-034.

Function
REQ-020 access = mem_memread | mem_memwrite, where memwrite has priority if both are set.
REQ-021 pcsrc SHALL equal (mem_branch & mem_zero) | mem_uncond_branch, combinationally; branch_target SHALL equal mem_nextseqpc.
REQ-022 FSM states SHALL be IDLE and WAIT.
- IDLE, access & !dmem_ack -> WAIT.
- WAIT, dmem_ack -> IDLE.
- Otherwise the FSM holds its state.
REQ-023 dmem_req SHALL equal access & !mem_err in IDLE or WAIT; dmem_addr = mem_aluout, dmem_wdata = mem_busB, dmem_we = mem_memwrite.
REQ-024 While dmem_req is high without dmem_ack, addr/we/wdata SHALL stay stable; upstream holds them via mem_stall.
REQ-025 Zero-wait ack (dmem_ack in the first request cycle) SHALL complete the access with no stall.
REQ-026 mem_stall SHALL equal dmem_req & !dmem_ack.
REQ-027 On each clock with mem_stall low, the MEM/WB outputs SHALL load:
- wb_readdata <= dmem_rdata if a read completes, else 0.
- wb_aluout, wb_rd, wb_mem2reg, wb_regwrite <= the matching mem_* inputs.
REQ-028 On each clock with mem_stall high, the block SHALL insert a bubble: wb_regwrite <= 0, wb_mem2reg <= 0, other wb_* unchanged.
REQ-029 An 8-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-030 Reaching 255 without ack SHALL force IDLE, set mem_err, and cause one bubble.
REQ-031 mem_err SHALL stay set until reset, and SHALL suppress further dmem_req; the pipeline continues, loads return 0, stores are dropped.
REQ-032 dmem_ack outside an outstanding request SHALL be ignored.

Reset
REQ-033 While resetl is low, the following SHALL apply:
- dmem_req SHALL be forced to 0.
- At the clock edge, state -> IDLE, counter -> 0, mem_err -> 0, mem_misalign -> 0, and all wb_* -> 0.
- Reset taken in WAIT SHALL abandon the access, with no write-back.

Configuration
REQ-034 With MEM_ALIGN_CHECK_EN defined:
- An access with mem_aluout[2:0] != 0 SHALL issue no dmem_req and no stall.
- mem_misalign SHALL pulse for 1 cycle (registered).
- That instruction SHALL write back with wb_regwrite = 0.
Without MEM_ALIGN_CHECK_EN, the address SHALL pass unchecked and mem_misalign SHALL be tied 0.

Verification
REQ-035 Load, mem_aluout=0x100, ack on 3rd request cycle, rdata=0xDEADBEEF -> mem_stall high 2 cycles, one bubble pair, then wb_readdata=0xDEADBEEF, wb_regwrite=1.
REQ-036 Store with zero-wait ack, busB=0x55 -> dmem_we=1, wdata=0x55 for 1 cycle, mem_stall never asserted.
REQ-037 mem_branch=1, mem_zero=1, nextseqpc=0x40 -> pcsrc=1, branch_target=0x40; with mem_zero=0 -> pcsrc=0; mem_uncond_branch=1 -> pcsrc=1.
REQ-038 Load with no ack -> mem_stall high 255 cycles, then mem_err=1, dmem_req=0 thereafter.
REQ-039 resetl low during WAIT -> next edge: state IDLE, dmem_req=0, all wb_*=0.
REQ-040 With MEM_ALIGN_CHECK_EN, a load at 0x103 -> dmem_req=0, mem_misalign pulses once, wb_regwrite=0.
